// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame controller: FSM states,
// 3x3 neighbour offset tables and output pixel levels.
package sobel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_CALC,
        S_WRITE
    } state_t;

    localparam int NBR_CNT = 8;

    localparam logic [7:0] PIX_LO = 8'd0;
    localparam logic [7:0] PIX_HI = 8'd255;

    // Neighbour n=0..7 in raster order around the centre pixel.
    localparam int ROW_OFS [NBR_CNT] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int COL_OFS [NBR_CNT] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    function automatic int nbr_delta(input int img_w, input logic [2:0] n);
        return ROW_OFS[n] * img_w + COL_OFS[n];
    endfunction

endpackage

// File: rtl/sobel_addr_gen.sv
// Raster-scan position tracker: row/column counters, border detection and
// pixel/neighbour address generation for the current and the next pixel.
module sobel_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic              use_nxt_i,
    input  logic [2:0]        nbr_i,
    output logic [ADDR_W-1:0] pix_addr_o,
    output logic [ADDR_W-1:0] nxt_addr_o,
    output logic [ADDR_W-1:0] nbr_addr_o,
    output logic              border_o,
    output logic              nxt_border_o,
    output logic              last_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADDR_W-1:0] pix_q;

    function automatic logic on_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return (r == '0) || (r == RW'(IMG_H - 1)) || (c == '0) || (c == CW'(IMG_W - 1));
    endfunction

    always_comb begin
        row_d = row_q;
        col_d = col_q + CW'(1);
        if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
        end
    end

    assign border_o     = on_border(row_q, col_q);
    assign nxt_border_o = on_border(row_d, col_d);
    assign last_o       = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    // Raster order makes r*IMG_W+c a plain incrementing address.
    assign pix_addr_o = pix_q;
    assign nxt_addr_o = pix_q + ADDR_W'(1);
    assign nbr_addr_o = (use_nxt_i ? nxt_addr_o : pix_q) + ADDR_W'(nbr_delta(IMG_W, nbr_i));

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            row_q <= '0;
            col_q <= '0;
            pix_q <= '0;
        end else if (advance_i) begin
            row_q <= row_d;
            col_q <= col_d;
            pix_q <= nxt_addr_o;
        end
    end

endmodule

// File: rtl/sobel_ctrl.sv
// Sobel frame sequencer: scans the image, fetches 3x3 neighbourhoods for the
// external kernel and writes edge results. Cycle counter under SOBEL_CTRL_PERF_CNT_EN.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing neighbour reads n=0..7, capturing n-1
// LAST    | capturing neighbour 7, no read
// CALC    | kernel inputs stable while the kernel registers its result
// WRITE   | writing current pixel result (border pixels come here directly)
module sobel_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [10:0]       th,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        k_in0,
    output logic [7:0]        k_in1,
    output logic [7:0]        k_in2,
    output logic [7:0]        k_in3,
    output logic [7:0]        k_in4,
    output logic [7:0]        k_in5,
    output logic [7:0]        k_in6,
    output logic [7:0]        k_in7,
    output logic [10:0]       k_th,
    input  logic              k_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [31:0]       cycle_cnt
);

    state_t            state_q;
    logic              busy_q, done_q, rd_en_q, wr_en_q;
    logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
    logic [10:0]       k_th_q;
    logic [7:0]        k_in_q [NBR_CNT];
    logic [2:0]        nbr_q;

    logic              start_ok, advance, use_nxt;
    logic [2:0]        nbr_sel;
    logic [ADDR_W-1:0] pix_addr, nxt_addr, nbr_addr;
    logic              border, nxt_border, last_pix;

    assign start_ok = (state_q == S_IDLE) && start && !abort;
    assign advance  = (state_q == S_WRITE) && !abort && !last_pix;
    assign use_nxt  = (state_q == S_WRITE);
    assign nbr_sel  = use_nxt ? 3'd0 : nbr_q + 3'd1;

    sobel_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (start_ok),
        .advance_i    (advance),
        .use_nxt_i    (use_nxt),
        .nbr_i        (nbr_sel),
        .pix_addr_o   (pix_addr),
        .nxt_addr_o   (nxt_addr),
        .nbr_addr_o   (nbr_addr),
        .border_o     (border),
        .nxt_border_o (nxt_border),
        .last_o       (last_pix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            k_th_q    <= '0;
            nbr_q     <= '0;
            for (int i = 0; i < NBR_CNT; i++) k_in_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
                wr_en_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Pixel (0,0) is always a border pixel, so go straight to WRITE.
                        if (start_ok) begin
                            k_th_q    <= th;
                            busy_q    <= 1'b1;
                            state_q   <= S_WRITE;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= '0;
                        end
                    end
                    S_FETCH: begin
                        if (nbr_q != 3'd0) k_in_q[nbr_q - 3'd1] <= rd_data;
                        if (nbr_q == 3'(NBR_CNT - 1)) begin
                            state_q <= S_LAST;
                            rd_en_q <= 1'b0;
                        end else begin
                            nbr_q     <= nbr_q + 3'd1;
                            rd_addr_q <= nbr_addr;
                        end
                    end
                    S_LAST: begin
                        k_in_q[NBR_CNT-1] <= rd_data;
                        state_q           <= S_CALC;
                    end
                    S_CALC: begin
                        state_q   <= S_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= pix_addr;
                    end
                    S_WRITE: begin
                        wr_en_q <= 1'b0;
                        if (last_pix) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (nxt_border) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= nxt_addr;
                        end else begin
                            state_q   <= S_FETCH;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= nbr_addr;
                            nbr_q     <= 3'd0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // k_result is already registered in the kernel and only valid in WRITE.
    assign wr_data = (state_q == S_WRITE && !border && k_result) ? PIX_HI : PIX_LO;

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign k_th    = k_th_q;
    assign k_in0   = k_in_q[0];
    assign k_in1   = k_in_q[1];
    assign k_in2   = k_in_q[2];
    assign k_in3   = k_in_q[3];
    assign k_in4   = k_in_q[4];
    assign k_in5   = k_in_q[5];
    assign k_in6   = k_in_q[6];
    assign k_in7   = k_in_q[7];

`ifdef SOBEL_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            cycle_cnt_q <= '0;
        end else if (busy_q) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule
